// File: rtl/usb_fs_in_arb_rr.sv
// Round-robin, packet-granular arbiter sharing the write side of one IN endpoint
// buffer among NUM_REQ data sources; a grant lasts through the host ACK.
module usb_fs_in_arb_rr #(
  parameter int NUM_REQ            = 3,
  parameter int MAX_IN_PACKET_SIZE = 32,
  parameter int MAX_BURST          = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  input  logic [NUM_REQ-1:0]   req_data_put,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_data_done,
  output logic [NUM_REQ-1:0]   req_data_free,
  output logic [NUM_REQ-1:0]   req_acked,
  input  logic                 in_ep_data_free,
  output logic                 in_ep_data_put,
  output logic [7:0]           in_ep_data,
  output logic                 in_ep_data_done,
  input  logic                 in_ep_acked,
  input  logic                 ep_reset,
  output logic                 busy
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_IN_PACKET_SIZE + 1);
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PUT      = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(MAX_IN_PACKET_SIZE - 1);
  localparam logic [4:0]       BURST_LIM = 5'(MAX_BURST);

  logic [1:0]         state_r, state_nxt_s;
  logic [IDX_W-1:0]   g_idx_r, g_idx_nxt_s, rr_ptr_r, rr_ptr_nxt_s, pick_s;
  logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
  logic [CNT_W-1:0]   byte_cnt_r, byte_cnt_nxt_s;
  logic [3:0]         burst_cnt_r, burst_cnt_nxt_s;
  logic               sel_req_s, sel_put_s, sel_done_s;
  logic [7:0]         sel_data_s;
  logic               st_put_s, fwd_put_s, forced_done_s, full_s, ack_s, burst_more_s;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    next_idx = (idx == LAST_IDX) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
  endfunction

  // First requester at or after ptr, wrapping; ptr itself when nobody asks
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    idx     = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = next_idx(idx);
    end
  endfunction

  assign pick_s = rr_pick(req, rr_ptr_r);

  // Route the granted requester's request, strobes and byte
  always_comb begin
    sel_req_s  = 1'b0;
    sel_put_s  = 1'b0;
    sel_done_s = 1'b0;
    sel_data_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_req_s  = sel_req_s  | (req[i]           & (g_idx_r == IDX_W'(i)));
      sel_put_s  = sel_put_s  | (req_data_put[i]  & (g_idx_r == IDX_W'(i)));
      sel_done_s = sel_done_s | (req_data_done[i] & (g_idx_r == IDX_W'(i)));
      sel_data_s = sel_data_s | (req_data[8*i +: 8] & {8{g_idx_r == IDX_W'(i)}});
    end
  end

  assign st_put_s  = (state_r == ST_PUT);
  assign fwd_put_s = st_put_s & sel_put_s & in_ep_data_free;
  // An abandoned packet that already holds data must still be closed toward the engine
  assign forced_done_s = st_put_s & ~sel_req_s & ~sel_done_s &
                         ((byte_cnt_r != {CNT_W{1'b0}}) | fwd_put_s);
  assign full_s        = fwd_put_s & (byte_cnt_r == LAST_BYTE);
  assign ack_s         = (state_r == ST_WAIT_ACK) & in_ep_acked & ~ep_reset;
  assign burst_more_s  = ({1'b0, burst_cnt_r} + 5'd1) < BURST_LIM;

  assign grant           = grant_r;
  assign in_ep_data_put  = fwd_put_s;
  assign in_ep_data      = st_put_s ? sel_data_s : 8'h00;
  assign in_ep_data_done = st_put_s & (sel_done_s | forced_done_s);
  assign req_data_free   = (st_put_s & in_ep_data_free) ? grant_r : {NUM_REQ{1'b0}};
  assign req_acked       = ack_s ? grant_r : {NUM_REQ{1'b0}};
  assign busy            = (state_r != ST_IDLE);

  // Next-state and register update decisions
  always_comb begin
    state_nxt_s     = state_r;
    g_idx_nxt_s     = g_idx_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    grant_nxt_s     = grant_r;
    byte_cnt_nxt_s  = byte_cnt_r;
    burst_cnt_nxt_s = burst_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_nxt_s     = ST_PUT;
          g_idx_nxt_s     = pick_s;
          grant_nxt_s     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
          byte_cnt_nxt_s  = {CNT_W{1'b0}};
          burst_cnt_nxt_s = 4'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PUT: begin
        byte_cnt_nxt_s = byte_cnt_r + {{(CNT_W-1){1'b0}}, fwd_put_s};
        if (sel_done_s || full_s || forced_done_s) begin
          state_nxt_s = ST_WAIT_ACK;
        end else if (!sel_req_s) begin
          state_nxt_s  = ST_IDLE;
          grant_nxt_s  = {NUM_REQ{1'b0}};
          rr_ptr_nxt_s = next_idx(g_idx_r);
        end else begin
          state_nxt_s = ST_PUT;
        end
      end
      ST_WAIT_ACK: begin
        if (in_ep_acked) begin
          burst_cnt_nxt_s = burst_cnt_r + 4'd1;
          if (sel_req_s && burst_more_s) begin
            state_nxt_s    = ST_PUT;
            byte_cnt_nxt_s = {CNT_W{1'b0}};
          end else begin
            state_nxt_s  = ST_IDLE;
            grant_nxt_s  = {NUM_REQ{1'b0}};
            rr_ptr_nxt_s = next_idx(g_idx_r);
          end
        end else begin
          state_nxt_s = ST_WAIT_ACK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = {NUM_REQ{1'b0}};
      end
    endcase
    // Endpoint reset abandons everything but keeps the fairness pointer
    if (ep_reset) begin
      state_nxt_s     = ST_IDLE;
      grant_nxt_s     = {NUM_REQ{1'b0}};
      byte_cnt_nxt_s  = {CNT_W{1'b0}};
      burst_cnt_nxt_s = 4'd0;
      rr_ptr_nxt_s    = rr_ptr_r;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State and arbitration registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      g_idx_r     <= {IDX_W{1'b0}};
      rr_ptr_r    <= {IDX_W{1'b0}};
      grant_r     <= {NUM_REQ{1'b0}};
      byte_cnt_r  <= {CNT_W{1'b0}};
      burst_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_nxt_s;
      g_idx_r     <= g_idx_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      grant_r     <= grant_nxt_s;
      byte_cnt_r  <= byte_cnt_nxt_s;
      burst_cnt_r <= burst_cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_usb_fs_in_arb_rr.sv
// Randomized scoreboard bench for usb_fs_in_arb_rr: the driver predicts grant,
// byte, done, ack and release events; a negedge monitor pops and compares them.
module tb_usb_fs_in_arb_rr;
  localparam int N      = 3;
  localparam int MPS    = 32;
  localparam int MB     = 4;
  localparam int NSESS  = 150;
  localparam int K_GRANT = 0, K_IDLE = 1, K_BYTE = 2, K_DONE = 3, K_ACK = 4;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]   req, grant, req_data_put, req_data_done, req_data_free, req_acked;
  logic [8*N-1:0] req_data;
  logic in_ep_data_free, in_ep_data_put, in_ep_data_done, in_ep_acked, ep_reset, busy;
  logic [7:0] in_ep_data;

  typedef struct { int kind; int who; int data; } ev_t;
  ev_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;
  logic [N-1:0] prev_grant = '0;
  string kname [5] = '{"grant", "idle", "byte", "done", "ack"};

  int w, rr_m, nb, kind, n, cnt, r;
  bit cont, sess_done, p, f;
  logic [7:0] d;
  logic [N-1:0] mask;

  always #5 clk = ~clk;

  usb_fs_in_arb_rr #(.NUM_REQ(N), .MAX_IN_PACKET_SIZE(MPS), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .req_data_put(req_data_put), .req_data(req_data), .req_data_done(req_data_done),
    .req_data_free(req_data_free), .req_acked(req_acked),
    .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put),
    .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
    .in_ep_acked(in_ep_acked), .ep_reset(ep_reset), .busy(busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int who, input int dat);
    ev_t e;
    e.kind = k; e.who = who; e.data = dat;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int expv);
    n_checks++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, expv);
  endtask

  task automatic observe(input int k, input int who, input int dat);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected %s: got who=%0h data=%0h, expected no event", kname[k], who, dat);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == k && e.who == who && e.data == dat) n_pass++;
      else $display("FAIL %s: got %s who=%0h data=%0h, expected %s who=%0h data=%0h at %0t",
                    kname[e.kind], kname[k], who, dat, kname[e.kind], e.who, e.data, $time);
    end
  endtask

  // Non-granted requesters babble on their lines; the arbiter must ignore them
  task automatic scramble(input int g);
    for (int i = 0; i < N; i++) begin
      if (i != g) begin
        req_data_put[i]   = 1'($urandom);
        req_data_done[i]  = 1'($urandom);
        req_data[8*i +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic own(input bit op, input logic [7:0] od, input bit odone);
    req_data_put[w]    = op;
    req_data[8*w +: 8] = od;
    req_data_done[w]   = odone;
  endtask

  function automatic int rr_pick_m(input logic [N-1:0] m, input int ptr);
    for (int k = 0; k < N; k++) if (m[(ptr + k) % N]) return (ptr + k) % N;
    return ptr;
  endfunction

  // Monitor: turn DUT activity into events and compare against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_grant == '0 && grant != '0) observe(K_GRANT, int'(grant), int'(busy));
      if (prev_grant != '0 && grant == '0) observe(K_IDLE, int'(grant), int'(busy));
      if (in_ep_data_put) observe(K_BYTE, int'(grant), int'({req_data_free, in_ep_data}));
      if (in_ep_data_done) observe(K_DONE, int'(grant), 0);
      if (req_acked != '0) observe(K_ACK, int'(req_acked), 0);
    end
    prev_grant <= grant;
  end

  initial begin
    reset = 1'b0; req = '1; req_data_put = '1; req_data_done = '1; req_data = '1;
    in_ep_data_free = 1'b1; in_ep_acked = 1'b1; ep_reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_put", int'(in_ep_data_put), 0);
    chk("rst_done", int'(in_ep_data_done), 0);
    chk("rst_acked", int'(req_acked), 0);
    chk("rst_free", int'(req_data_free), 0);
    chk("rst_data", int'(in_ep_data), 0);
    @(posedge clk); #1;
    req = '0; in_ep_acked = 1'b0; reset = 1'b1; mon_en = 1'b1;
    rr_m = 0; w = 0;

    for (int s = 0; s < NSESS; s++) begin
      if ($urandom % 3 == 0) begin
        req = '0;
        repeat ($urandom_range(1, 3)) begin scramble(-1); cyc(); end
      end
      mask = N'($urandom_range(1, (1 << N) - 1));
      req = mask;
      w = rr_pick_m(mask, rr_m);
      push(K_GRANT, 1 << w, 1);
      scramble(-1); in_ep_data_free = 1'($urandom); in_ep_acked = 1'b0; ep_reset = 1'b0;
      cyc();
      nb = 0; sess_done = 1'b0;
      while (!sess_done) begin
        r = $urandom % 20;
        kind = (r < 9 || r > 17) ? 0 : (r < 12) ? 1 : (r < 16) ? 2 : 3;
        n = (kind == 0) ? $urandom_range(0, 10) : (kind == 1) ? MPS : (kind == 2) ? $urandom_range(1, 6) : 0;
        cnt = 0;
        while (cnt < n) begin
          p = ($urandom % 4 != 0); f = ($urandom % 4 != 0); d = 8'($urandom);
          own(p, d, 1'b0); scramble(w); in_ep_data_free = f;
          if (p && f) begin push(K_BYTE, 1 << w, ((1 << w) << 8) | int'(d)); cnt++; end
          cyc();
        end
        if (kind == 0) begin
          p = 1'($urandom); f = 1'($urandom); d = 8'($urandom);
          own(p, d, 1'b1); scramble(w); in_ep_data_free = f;
          if (p && f) push(K_BYTE, 1 << w, ((1 << w) << 8) | int'(d));
          push(K_DONE, 1 << w, 0);
          cyc();
        end else if (kind == 2) begin
          req[w] = 1'b0; own(1'b0, 8'h00, 1'b0); scramble(w);
          push(K_DONE, 1 << w, 0);
          cyc();
        end else if (kind == 3) begin
          req[w] = 1'b0; own(1'b0, 8'h00, 1'b0); scramble(w);
          push(K_IDLE, 0, 0);
          rr_m = (w + 1) % N;
          cyc();
          sess_done = 1'b1;
        end
        if (!sess_done) begin
          // Waiting for the host: nothing the requesters do may reach the engine
          repeat ($urandom_range(0, 3)) begin
            own($urandom % 4 != 0, 8'($urandom), 1'($urandom)); scramble(w);
            in_ep_data_free = ($urandom % 4 != 0);
            cyc();
          end
          own(1'($urandom), 8'($urandom), 1'($urandom)); scramble(w);
          if ($urandom % 10 == 0) begin
            ep_reset = 1'b1; in_ep_acked = 1'($urandom);
            push(K_IDLE, 0, 0);
            cyc();
            ep_reset = 1'b0; in_ep_acked = 1'b0;
            sess_done = 1'b1;
          end else begin
            in_ep_acked = 1'b1;
            push(K_ACK, 1 << w, 0);
            cont = (kind != 2) && ($urandom % 4 != 0);
            if (!cont) req = '0;
            if (cont && nb + 1 < MB) begin
              nb++;
            end else begin
              push(K_IDLE, 0, 0);
              rr_m = (w + 1) % N;
              sess_done = 1'b1;
            end
            cyc();
            in_ep_acked = 1'b0;
          end
        end
      end
    end

    // Asynchronous reset in the middle of a packet clears everything at once
    req = '0; cyc();
    mask = N'($urandom_range(1, (1 << N) - 1));
    req = mask; w = rr_pick_m(mask, rr_m);
    push(K_GRANT, 1 << w, 1);
    cyc();
    d = 8'($urandom); own(1'b1, d, 1'b0); in_ep_data_free = 1'b1;
    push(K_BYTE, 1 << w, ((1 << w) << 8) | int'(d));
    @(negedge clk); #1;
    mon_en = 1'b0; reset = 1'b0;
    #1;
    chk("arst_grant", int'(grant), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_put", int'(in_ep_data_put), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/usb_fs_in_arb_rr.md
Name: usb_fs_in_arb_rr

Overview:
- Round-robin, packet-granular arbiter that shares the write side of one IN endpoint buffer (free/put/data/done/acked) among NUM_REQ requesters.
- Sits between function-level data sources (e.g. descriptor ROM reader, status reporter) and a single endpoint slot of the IN protocol engine.
- Holds a grant for a whole packet, through the host ACK, and optionally for a burst of consecutive packets.

Parameters:
- NUM_REQ, 3: number of requesters, 2..8.
- MAX_IN_PACKET_SIZE, 32: bytes per full packet; must match the protocol engine's per-endpoint buffer size.
- MAX_BURST, 4: maximum consecutive packets per grant before forced rotation, 1..15.

Ports:
- clk  in  1: system clock.
- reset  in  1: asynchronous, active-low reset (asserted when 0).
- req  in  NUM_REQ: requester i wants the endpoint.
- grant  out  NUM_REQ: one-hot registered grant.
- req_data_put  in  NUM_REQ: byte strobe per requester.
- req_data  in  8*NUM_REQ: byte per requester; requester i uses bits [8i+7:8i].
- req_data_done  in  NUM_REQ: end-of-packet strobe per requester.
- req_data_free  out  NUM_REQ: grant[i] & in_ep_data_free & (state==PUT).
- req_acked  out  NUM_REQ: one-cycle pulse when requester i's packet is ACKed.
- in_ep_data_free  in  1: engine buffer slot accepts a byte.
- in_ep_data_put  out  1: byte strobe to engine.
- in_ep_data  out  8: byte to engine.
- in_ep_data_done  out  1: end-of-packet to engine.
- in_ep_acked  in  1: engine reports packet ACKed.
- ep_reset  in  1: endpoint reset (bus reset / SET_CONFIGURATION).
- busy  out  1: state != IDLE.

Behaviour:
- States: IDLE, PUT, WAIT_ACK.
- Registers: g_idx, rr_ptr, byte_cnt ($clog2(MAX_IN_PACKET_SIZE+1) bits), burst_cnt (4 bits).
- Reset values: all registers and grant = 0; state IDLE; all outputs 0.
- IDLE:
  - If any req is high, select the first i with req[i]=1, searching from rr_ptr upward with wrap modulo NUM_REQ.
  - Next cycle: grant[i]=1, g_idx=i, byte_cnt=0, burst_cnt=0, state PUT. Latency from req to grant is 1 cycle.
- PUT outputs (combinational from g_idx):
  - in_ep_data_put = req_data_put[g] & in_ep_data_free.
  - in_ep_data = req_data[g].
  - in_ep_data_done = req_data_done[g] | forced_done.
- PUT counting and exits:
  - A put presented while free=0 is dropped and not counted.
  - byte_cnt increments on each forwarded put.
  - On done, or on the forwarded put that makes byte_cnt == MAX_IN_PACKET_SIZE: go to WAIT_ACK.
  - Done with byte_cnt=0 is legal and yields a zero-length packet.
  - Put and done in the same cycle: the byte is forwarded and the packet closes.
  - req[g] drops with byte_cnt=0 and no done: release grant, state IDLE, rr_ptr=g+1 mod NUM_REQ.
  - req[g] drops with byte_cnt>0: forced_done pulses for 1 cycle, then state WAIT_ACK.
- WAIT_ACK:
  - Inputs from all requesters are ignored and no puts are forwarded.
  - On in_ep_acked: req_acked[g] pulses in the same cycle, burst_cnt increments.
  - If req[g]=1 and burst_cnt+1 < MAX_BURST: stay granted, byte_cnt=0, state PUT.
  - Otherwise: grant=0, rr_ptr=g+1 mod NUM_REQ, state IDLE.
  - No timeout: NAK/retry is handled by the engine, and the arbiter waits indefinitely.
- ep_reset, any state: next cycle state IDLE, grant=0, byte_cnt=0, burst_cnt=0, no req_acked pulse, rr_ptr unchanged.
- Simultaneous ep_reset and in_ep_acked: ep_reset wins.
- Asynchronous reset mid-packet: everything clears immediately; the engine's own reset is responsible for its buffer.
- Grant never changes mid-packet; at most one grant bit is ever high.

Test Plan:
- Single requester: req[1]=1, 5 puts then done, free=1 → grant=3'b010 one cycle after req; 5 in_ep_data_put pulses carrying the exact bytes; done forwarded; req_acked[1] pulses on in_ep_acked; req dropped → grant=0, rr_ptr=2.
- Full packet: requester 0 issues 32 puts with no done → WAIT_ACK after 32nd forwarded put; a 33rd put is not forwarded; in_ep_data_done stays 0.
- Round-robin: req=3'b111 held, MAX_BURST=1, ACK every packet → grant order 0,1,2,0.
- Burst limit: req[2] held, MAX_BURST=4 → 4 ACKed packets under one grant, then rotation.
- Backpressure and abandon: free toggles 0/1 while requester 1 puts every cycle → only puts with free=1 forwarded. Then req[1] drops after 3 bytes → forced done pulse, then WAIT_ACK.
- ep_reset in WAIT_ACK coincident with in_ep_acked → no req_acked pulse, IDLE next cycle, grant=0, rr_ptr unchanged.
